// File: rtl/p2s_arb_pkg.sv
// p2s_arb_pkg: shared types and helpers for the P_to_S frame arbiter
package p2s_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    // Width helper that never returns zero, so single-entry counters/indices stay legal
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p2s_frame_arbiter_rr_picker.sv
// rr_picker: combinational round-robin find-first starting at a pointer
module rr_picker
    import p2s_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant_onehot,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    // scan upward from ptr with wrap, first set request wins
    always_comb begin
        logic [W-1:0] idx;
        idx          = '0;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = W'((int'(ptr) + i) % N);
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/p2s_frame_arbiter.sv
// p2s_frame_arbiter: round-robin sharing of one P_to_S converter with per-beat source/first/last tags
module p2s_frame_arbiter
    import p2s_arb_pkg::*;
#(
    parameter  int N_REQ           = 4,
    parameter  int PARALLEL_LENGTH = 32,
    parameter  int SERIAL_LENGTH   = 1,
    localparam int SW              = clog2_min1(N_REQ)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [N_REQ-1:0]                            req,
    input  logic [N_REQ-1:0][0:PARALLEL_LENGTH-1][31:0] idata,
    output logic [N_REQ-1:0]                            ack,
    output logic                                        p2s_ien,
    output logic [0:PARALLEL_LENGTH-1][31:0]            p2s_idata,
    input  logic                                        p2s_full,
    input  logic                                        p2s_oen,
    output logic [SW-1:0]                               osrc,
    output logic                                        ofirst,
    output logic                                        olast,
    output logic                                        busy
);

    localparam int             BEATS = PARALLEL_LENGTH / SERIAL_LENGTH;
    localparam int             CW    = clog2_min1(BEATS);
    localparam logic [CW-1:0]  LAST  = CW'(BEATS - 1);
    localparam logic [SW-1:0]  TOP   = SW'(N_REQ - 1);

    generate
        if (PARALLEL_LENGTH % SERIAL_LENGTH != 0) begin : g_len_chk
            $error("PARALLEL_LENGTH must be a multiple of SERIAL_LENGTH");
        end
    endgenerate

    state_t           state, state_nx;
    logic [SW-1:0]    rr_ptr, src, pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic             pick_any, grant, beat;
    logic [CW-1:0]    cnt;

    rr_picker #(.N(N_REQ), .W(SW)) u_pick (
        .req          (req),
        .ptr          (rr_ptr),
        .grant_onehot (pick_oh),
        .grant_idx    (pick_idx),
        .any          (pick_any)
    );

    // a grant needs an idle arbiter and an empty converter
    assign grant = (state == IDLE) && pick_any && !p2s_full;
    assign beat  = (state == SEND) && p2s_oen;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: grant -> one load cycle -> serialize until the last beat
    always_comb begin
        state_nx = (state == IDLE) ? (grant ? LOAD : IDLE) :
                   (state == LOAD) ? SEND :
                   (p2s_oen && cnt == LAST) ? IDLE : SEND;
    end

    // grant pulse, load strobe, captured frame and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= '0;
            p2s_ien   <= 1'b0;
            p2s_idata <= '0;
            src       <= '0;
            rr_ptr    <= '0;
        end else begin
            ack     <= grant ? pick_oh : '0;
            p2s_ien <= grant;
            if (grant) begin
                p2s_idata <= idata[pick_idx];
                src       <= pick_idx;
                rr_ptr    <= (pick_idx == TOP) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    // beat counter, only advanced by converter output beats while serializing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (grant) cnt <= '0;
        else if (beat)  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign ofirst = beat && (cnt == '0);
    assign olast  = beat && (cnt == LAST);
    assign osrc   = src;
    assign busy   = (state != IDLE);

endmodule

// File: doc/p2s_frame_arbiter.md
# p2s_frame_arbiter

- Shares one `P_to_S_converter` instance between `N_REQ` frame producers.
- Each producer offers a full parallel frame with a request. The block grants round-robin, loads the winner's frame into the converter, then tracks the serialized beats.
- Emits source-id / first / last tags aligned with the converter's `oen`, so downstream logic can demultiplex the serial stream.
- Sits between the producer array and the converter's `ien/idata/full` inputs; observes the converter's `oen`.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `PARALLEL_LENGTH`, 32: words per frame; must equal the converter's parameter.
- `SERIAL_LENGTH`, 1: words per converter beat; `PARALLEL_LENGTH % SERIAL_LENGTH == 0` is checked at elaboration.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `[N_REQ-1:0]`: frame requests, one per producer.
- `idata` in `[N_REQ-1:0][0:PARALLEL_LENGTH-1][31:0]`: producer frames; valid whenever the matching `req` is high.
- `ack` out `[N_REQ-1:0]`: one-cycle one-hot grant pulse; the frame has been taken.
- `p2s_ien` out 1: load strobe to the converter's `ien`.
- `p2s_idata` out `[0:PARALLEL_LENGTH-1][31:0]`: to the converter's `idata`.
- `p2s_full` in 1: from the converter's `full`.
- `p2s_oen` in 1: from the converter's `oen`.
- `osrc` out `SW = max(1,$clog2(N_REQ))`: index of the frame being serialized.
- `ofirst` out 1: `p2s_oen` of beat 0 of the frame.
- `olast` out 1: `p2s_oen` of the final beat of the frame.
- `busy` out 1: state ≠ IDLE.

## Operation
- `BEATS = PARALLEL_LENGTH/SERIAL_LENGTH`; beat counter width `max(1,$clog2(BEATS))`.
- FSM states:
  - **IDLE**:
    - Condition: `|req && !p2s_full`.
    - Winner = first set `req` bit at or after `rr_ptr`, searching upward with wrap.
    - Registered actions: `ack[w]<=1`, `p2s_ien<=1`, `p2s_idata<=idata[w]`, `src<=w`, `rr_ptr<=(w+1)%N_REQ`, beat counter ← 0.
    - Next state: LOAD.
  - **LOAD**: one cycle. `p2s_ien` is high during this cycle and the converter captures at its end. Next state SEND; `ack` and `p2s_ien` return to 0.
  - **SEND**:
    - Each `p2s_oen` increments the beat counter.
    - When `p2s_oen` arrives with counter `== BEATS-1`: next state IDLE, counter ← 0.
    - `fct` stalls are invisible except as gaps in `p2s_oen`.
- Tags, combinational from state/counter/`p2s_oen`:
  - `ofirst = SEND && p2s_oen && cnt==0`.
  - `olast = SEND && p2s_oen && cnt==BEATS-1`.
  - `osrc = src`, held from LOAD until the next grant.
  - When `BEATS==1`, `ofirst` and `olast` assert together.
- `p2s_oen` seen in IDLE or LOAD is ignored: no tags, no count.
- A `req` dropped before the grant edge is simply not granted. There is no penalty, and `rr_ptr` is unchanged.
- The block never drives `p2s_ien` while `p2s_full` is high.
- Reset values: state IDLE; `ack`, `p2s_ien`, `busy` = 0; `p2s_idata` = 0; `src`, `osrc`, `rr_ptr` = 0; `ofirst`, `olast` = 0.

## Timing
- Grant latency: `req` sampled high in IDLE at edge E → `ack`/`p2s_ien` high in cycle E+1 (LOAD) → converter `full` high after E+2.
- Earliest first `p2s_oen` is cycle E+3.
- Back-to-back frames: the `olast` edge returns the FSM to IDLE while the converter clears `full` at the same edge. The next grant is sampled one cycle later. Minimum gap is 3 cycles between a frame's last beat and the next frame's first beat.
- A saturated N-way request pattern grants cyclically 0,1,…,N-1,0. No requester waits more than `N_REQ-1` frames.
- Reset mid-frame:
  - The block returns to IDLE asynchronously.
  - The converter has no reset. It may still hold `full=1` and drain its frame.
  - The block emits no tags for those beats and waits for `p2s_full==0` before the next grant.

## Structure
- Package `p2s_arb_pkg`: state enum `{IDLE, LOAD, SEND}`; helper function `clog2_min1`.
- Sub-module `rr_picker #(N)`: combinational round-robin find-first from a pointer, with `req`/`ptr` in and `grant_onehot`/`grant_idx`/`any` out. It is reused by future converter arbiters.
- The top holds the FSM, pointer, beat counter, data mux register and tags.

## Test plan
- Single frame: `N_REQ=4`, `PARALLEL_LENGTH=8`, `SERIAL_LENGTH=1`, `req=4'b0100` at cycle 0 → `ack=4'b0100` at cycle 1; 8 `p2s_oen` beats with `osrc=2`; `ofirst` on beat 0, `olast` on beat 7; `busy` falls after `olast`.
- Round-robin fairness: `req=4'b1111` held for 8 frames → grant order 0,1,2,3,0,1,2,3; each `ack` is exactly one cycle.
- Stall: `fct` held high for 5 cycles mid-frame → beat count and tags unaffected; `olast` only on the 8th `oen`.
- Skip/withdraw: `rr_ptr=1`, `req=4'b1001` → grant 3, then 0. Dropping `req[3]` one cycle before the grant edge → grant 0.
- Full hold-off: force `p2s_full=1` with `req` pending → no `ack` or `p2s_ien` until `full` falls. `SERIAL_LENGTH=4`, `PARALLEL_LENGTH=8` → 2 beats; `ofirst`/`olast` on beats 0/1.
- Reset mid-SEND after beat 3 → outputs at reset values; residual converter beats produce no tags; next grant only after `p2s_full==0`.
